// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//
// Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock.
// Presents 1-based pixel coordinates to the image generator. Registers the
// returned colour onto the DAC pins. Delays hsync/vsync by the same number of
// cycles as the colour path, so sync stays pixel-aligned with colour.
//
// Ports
//   CLOCK_25     in   1   pixel clock (sole clock)
//   reset        in   1   asynchronous, active-high reset
//   x            out  12  pixel column 1..H_VISIBLE when visible, else 0
//   y            out  12  pixel row 1..V_VISIBLE on visible lines, else 0
//   visible      out  1   high when both x and y are non-zero
//   frame_start  out  1   one-cycle pulse coincident with x=1, y=1
//   color        in   3   pixel colour from the generator: [2]=R [1]=G [0]=B
//   vga_r/g/b    out  1   colour to DAC, forced 0 outside the visible area
//   hsync        out  1   active-low horizontal sync
//   vsync        out  1   active-low vertical sync
// -----------------------------------------------------------------------------
module vga_timing #(
    parameter int unsigned H_VISIBLE     = 640,
    parameter int unsigned H_FRONT       = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BACK        = 48,
    parameter int unsigned V_VISIBLE     = 480,
    parameter int unsigned V_FRONT       = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BACK        = 33,
    parameter int unsigned COLOR_LATENCY = 0
) (
    input  logic        CLOCK_25,
    input  logic        reset,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        visible,
    output logic        frame_start,
    input  logic [2:0]  color,
    output logic        vga_r,
    output logic        vga_g,
    output logic        vga_b,
    output logic        hsync,
    output logic        vsync
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
    localparam logic [11:0] V_VIS    = 12'(V_VISIBLE);
    localparam logic [11:0] HS_FIRST = 12'(H_VISIBLE + H_FRONT);
    localparam logic [11:0] HS_LAST  = 12'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST = 12'(V_VISIBLE + V_FRONT);
    localparam logic [11:0] VS_LAST  = 12'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_frame_start;
    logic [2:0]  r_rgb;

    // Element 0 of each shift register is the stage-1 value; element k is
    // that value delayed by k further cycles.
    logic [COLOR_LATENCY:0]   r_vis_sr;
    logic [COLOR_LATENCY+1:0] r_hs_sr;
    logic [COLOR_LATENCY+1:0] r_vs_sr;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_h_vis;
    logic w_v_vis;
    logic w_hs_active;
    logic w_vs_active;

    assign w_h_wrap    = (r_h_cnt == H_LAST);
    assign w_v_wrap    = (r_v_cnt == V_LAST);
    assign w_h_vis     = (r_h_cnt < H_VIS);
    assign w_v_vis     = (r_v_cnt < V_VIS);
    assign w_hs_active = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
    assign w_vs_active = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);

    // Raster counters: v_cnt advances only on the h_cnt wrap, so the
    // end-of-frame corner wraps both on the same edge.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + 12'd1;
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 12'd1;
            end
        end
    end

    // Stage 1 decode, the delay lines and the colour register.
    always_ff @(posedge CLOCK_25 or posedge reset) begin
        if (reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
            r_vis_sr      <= '0;
            r_hs_sr       <= '1;
            r_vs_sr       <= '1;
            r_rgb         <= '0;
        end else begin
            r_x           <= w_h_vis ? r_h_cnt + 12'd1 : '0;
            r_y           <= w_v_vis ? r_v_cnt + 12'd1 : '0;
            r_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            r_vis_sr[0]   <= w_h_vis && w_v_vis;
            r_hs_sr[0]    <= ~w_hs_active;
            r_vs_sr[0]    <= ~w_vs_active;
            for (int unsigned k = 1; k <= COLOR_LATENCY; k++) begin
                r_vis_sr[k] <= r_vis_sr[k-1];
            end
            // Sync gets one stage more than visible to cover the colour register.
            for (int unsigned k = 1; k <= COLOR_LATENCY + 1; k++) begin
                r_hs_sr[k] <= r_hs_sr[k-1];
                r_vs_sr[k] <= r_vs_sr[k-1];
            end
            r_rgb <= r_vis_sr[COLOR_LATENCY] ? color : 3'b000;
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign visible     = r_vis_sr[0];
    assign frame_start = r_frame_start;
    assign vga_r       = r_rgb[2];
    assign vga_g       = r_rgb[1];
    assign vga_b       = r_rgb[0];
    assign hsync       = r_hs_sr[COLOR_LATENCY+1];
    assign vsync       = r_vs_sr[COLOR_LATENCY+1];

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. Drives the 1-based `x`/`y` pixel coordinates consumed by `img_generator`. Registers the returned 3-bit `color` onto the DAC pins, delaying `hsync`/`vsync` so sync stays pixel-aligned with colour. Sits between the board clock and the VGA connector, wrapping the image pipeline.

## Interface
- `H_VISIBLE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync pulse width, in pixels
- `H_BACK`, 48: horizontal back porch, in pixels
- `V_VISIBLE`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BACK`, 33: vertical back porch, in lines
- `COLOR_LATENCY`, 0: cycles from `x`/`y` change to valid `color`; range 0..3

- `CLOCK_25`  in  1  pixel clock; sole clock
- `reset`  in  1  asynchronous, active-high; one clock, asynchronous active-high reset
- `x`  out  12  pixel column: 1..H_VISIBLE when visible, else 0
- `y`  out  12  pixel row: 1..V_VISIBLE when the line is visible, else 0
- `visible`  out  1  high when both `x` and `y` are non-zero
- `frame_start`  out  1  one-cycle pulse coincident with `x`=1, `y`=1
- `color`  in  3  pixel colour from `img_generator`; [2]=R, [1]=G, [0]=B
- `vga_r`, `vga_g`, `vga_b`  out  1 each  colour to DAC; forced 0 outside the visible area
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync

## Operation
- Totals: H_TOTAL = sum of H params = 800; V_TOTAL = sum of V params = 525.
- `h_cnt`: 0..H_TOTAL-1. Increments every cycle and wraps to 0.
- `v_cnt`: 0..V_TOTAL-1. Increments only when `h_cnt` wraps, and wraps to 0 after V_TOTAL-1.
- Stage 1 is registered from the counters:
  - `x` = `h_cnt`+1 if `h_cnt` < H_VISIBLE, else 0.
  - `y` = `v_cnt`+1 if `v_cnt` < V_VISIBLE, else 0.
  - `visible` = both conditions true.
  - `frame_start` = (`h_cnt`==0 && `v_cnt`==0).
  - raw hsync is low for `h_cnt` in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656, 751].
  - raw vsync is low for `v_cnt` in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490, 491], across the full 800-pixel lines.
- `y` holds constant for the whole line, including horizontal blanking. It is 0 only on blank lines.
- Colour path:
  - `visible` passes through a COLOR_LATENCY-deep shift register.
  - `color` is registered once: `vga_{r,g,b}` <= delayed `visible` ? `color` bits : 0.
- Sync path: raw hsync/vsync pass through a (COLOR_LATENCY+1)-deep shift register, so they align with `vga_*`.
- All arithmetic is unsigned, 12-bit; counters never exceed 799/524.

## Timing
- Reset, asynchronous, any cycle:
  - counters go to 0.
  - `x`, `y`, `visible`, `frame_start` go to 0.
  - `vga_r`, `vga_g`, `vga_b` go to 0.
  - `hsync`, `vsync` and every sync/visible shift stage go to 1 (inactive), resp. 0 for visible.
- First rising edge after reset release: stage 1 shows `x`=1, `y`=1, `visible`=1, `frame_start`=1; counters become 1,0.
- Latency:
  - counters → `x`/`y`: 1 cycle.
  - `x`/`y` → `vga_*` and `hsync`/`vsync`: COLOR_LATENCY+1 cycles.
- Line period is exactly 800 cycles; frame period is exactly 420000 cycles.
- `frame_start` is high for exactly 1 cycle per frame.
- Reset mid-frame aborts the raster immediately. No partial sync pulse is extended; sync returns high asynchronously.
- Simultaneous wrap (`h_cnt`=799, `v_cnt`=524): both counters go to 0 on the same edge.

## Test plan
- Reset values: assert `reset` with a random pre-state.
  - Required: `x`=`y`=0, `visible`=0, `hsync`=`vsync`=1, `vga_*`=0 on the same cycle, before any clock edge.
- Line scan: release reset.
  - `x` reads 1,2,…,640 on 640 consecutive cycles, then 0 for 160 cycles, then 1 again.
  - `y` stays 1 for all 800 cycles, then becomes 2.
- Hsync with COLOR_LATENCY=0: `hsync` is low for exactly 96 cycles, starting 657 cycles after the `frame_start` cycle.
- Vsync: `vsync` is low for exactly 1600 cycles per frame, starting 490×800+1 cycles after `frame_start`.
  - `y`=0 for lines 480..524, i.e. 45×800 cycles.
  - `frame_start` pulses are spaced 420000 cycles apart.
- Colour alignment with COLOR_LATENCY=1: model `color` = {x==5, 0, y==1} delayed 1 cycle.
  - `vga_r` is 1 on exactly one cycle per frame, 2 cycles after `x`=5.
  - `vga_b`=0 throughout horizontal blanking even while `color`≠0.
- Reset mid-frame: pulse `reset` for 3 cycles at `x`=320, `y`=200.
  - Outputs return to reset values during the pulse.
  - After release, `x`=1, `y`=1, `frame_start`=1 on the first edge.
